// File: rtl/alert_cond.sv
// alert_cond: condition generator feeding the piezo driver.
// Each of the battery and wheel-speed sample streams is block-averaged over
// 2^AVG_LOG2 samples. The averages then pass through a hysteresis and
// persistence qualifier, giving glitch-free batt_low and too_fast levels.
// en_steer is en_steer_in delayed by one register stage.
// Optional feature: define STICKY_BATT_LOW_EN to make batt_low latch until rst.

// One averaging + qualification channel. LOW_SENSE selects the threshold
// direction: 1 = set below SET_TH / clear at or above CLR_TH,
// 0 = set above SET_TH / clear at or below CLR_TH.
module alert_chan #(
   parameter int unsigned AVG_LOG2  = 2,
   parameter logic [11:0] SET_TH    = 12'h000,
   parameter logic [11:0] CLR_TH    = 12'h000,
   parameter bit          LOW_SENSE = 1'b1,
   parameter bit          STICKY    = 1'b0,
   parameter int unsigned PERSIST   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vld,
   input  logic [11:0] sample,
   output logic        flag
);

   localparam int unsigned         ACC_W     = 12 + AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] LAST_IDX  = '1;
   localparam logic [3:0]          PERSIST_C = 4'(PERSIST);

   localparam logic [0:0] ST_CLR = 1'b0;
   localparam logic [0:0] ST_SET = 1'b1;

   logic [AVG_LOG2-1:0] idx;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    sum;
   logic [11:0]         avg;
   logic                avg_vld;
   logic [0:0]          state;
   logic [3:0]          pc;
   logic                qual;

   // The accumulator is wide enough for a full window, so this sum never wraps.
   assign sum = acc + ACC_W'(sample);

   // Accumulate samples; on the last index register the truncated average.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         idx     <= '0;
         acc     <= '0;
         avg     <= '0;
         avg_vld <= 1'b0;
      end else begin
         avg_vld <= 1'b0;
         if (vld) begin
            if (idx == LAST_IDX) begin
               // Dropping the low AVG_LOG2 bits is the truncating divide.
               avg     <= sum[AVG_LOG2 +: 12];
               avg_vld <= 1'b1;
               acc     <= '0;
               idx     <= '0;
            end else begin
               acc <= sum;
               idx <= idx + 1'b1;
            end
         end
      end
   end

   // Decide whether the current average argues for leaving the current state.
   always_comb begin
      // NOTE: the default assignment up front keeps this block purely
      // combinational; without it some paths would infer a latch.
      qual = 1'b0;
      if (state == ST_CLR) begin
         qual = LOW_SENSE ? (avg < SET_TH) : (avg > SET_TH);
      end else if (!STICKY) begin
         qual = LOW_SENSE ? (avg >= CLR_TH) : (avg <= CLR_TH);
      end
   end

   // Persistence counter and flag state; only averages move the counter.
   // An average in the hysteresis band is non-qualifying and restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLR;
         pc    <= '0;
      end else if (avg_vld) begin
         if (!qual) begin
            pc <= '0;
         end else if (pc + 4'd1 == PERSIST_C) begin
            state <= ~state;
            pc    <= '0;
         end else begin
            pc <= pc + 4'd1;
         end
      end
   end

   assign flag = (state == ST_SET);

endmodule

module alert_cond #(
   parameter int unsigned AVG_LOG2   = 2,
   parameter logic [11:0] BATT_LO_TH = 12'hA98,
   parameter logic [11:0] BATT_HYST  = 12'h040,
   parameter logic [11:0] SPD_HI_TH  = 12'h600,
   parameter logic [11:0] SPD_HYST   = 12'h080,
   parameter int unsigned PERSIST    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        batt_vld,
   input  logic [11:0] batt,
   input  logic        spd_vld,
   input  logic [11:0] spd,
   input  logic        en_steer_in,
   output logic        batt_low,
   output logic        too_fast,
   output logic        en_steer
);

   // Release thresholds are computed at 13 bits and saturated into 12 bits.
   localparam logic [12:0] BATT_CLR_SUM = {1'b0, BATT_LO_TH} + {1'b0, BATT_HYST};
   localparam logic [11:0] BATT_CLR_TH  = BATT_CLR_SUM[12] ? 12'hFFF : BATT_CLR_SUM[11:0];
   localparam logic [11:0] SPD_CLR_TH   = (SPD_HYST > SPD_HI_TH) ? 12'h000
                                                                : (SPD_HI_TH - SPD_HYST);

`ifdef STICKY_BATT_LOW_EN
   localparam bit BATT_STICKY = 1'b1;
`else
   localparam bit BATT_STICKY = 1'b0;
`endif

   alert_chan #(
      .AVG_LOG2  (AVG_LOG2),
      .SET_TH    (BATT_LO_TH),
      .CLR_TH    (BATT_CLR_TH),
      .LOW_SENSE (1'b1),
      .STICKY    (BATT_STICKY),
      .PERSIST   (PERSIST)
   ) u_batt (
      .clk    (clk),
      .rst    (rst),
      .vld    (batt_vld),
      .sample (batt),
      .flag   (batt_low)
   );

   alert_chan #(
      .AVG_LOG2  (AVG_LOG2),
      .SET_TH    (SPD_HI_TH),
      .CLR_TH    (SPD_CLR_TH),
      .LOW_SENSE (1'b0),
      .STICKY    (1'b0),
      .PERSIST   (PERSIST)
   ) u_spd (
      .clk    (clk),
      .rst    (rst),
      .vld    (spd_vld),
      .sample (spd),
      .flag   (too_fast)
   );

   // Pass the steering enable through one register stage.
   always_ff @(posedge clk) begin
      if (rst) en_steer <= 1'b0;
      else     en_steer <= en_steer_in;
   end

endmodule

// File: tb/tb_alert_cond.sv
// Testbench for alert_cond: directed scenarios plus randomized regimes,
// checked cycle by cycle against a window-average / run-length reference model.
// Honours STICKY_BATT_LOW_EN the same way as the design.
module tb_alert_cond;

   localparam int AVG_LOG2   = 2;
   localparam int N          = 1 << AVG_LOG2;
   localparam int BATT_LO_TH = 'hA98;
   localparam int BATT_HYST  = 'h040;
   localparam int SPD_HI_TH  = 'h600;
   localparam int SPD_HYST   = 'h080;
   localparam int PERSIST    = 3;
   localparam int BATT_CLR   = (BATT_LO_TH + BATT_HYST > 4095) ? 4095 : BATT_LO_TH + BATT_HYST;
   localparam int SPD_CLR    = (SPD_HYST > SPD_HI_TH) ? 0 : SPD_HI_TH - SPD_HYST;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        batt_vld = 1'b0;
   logic [11:0] batt = '0;
   logic        spd_vld = 1'b0;
   logic [11:0] spd = '0;
   logic        en_steer_in = 1'b0;
   logic        batt_low;
   logic        too_fast;
   logic        en_steer;

   alert_cond #(
      .AVG_LOG2   (AVG_LOG2),
      .BATT_LO_TH (12'(BATT_LO_TH)),
      .BATT_HYST  (12'(BATT_HYST)),
      .SPD_HI_TH  (12'(SPD_HI_TH)),
      .SPD_HYST   (12'(SPD_HYST)),
      .PERSIST    (PERSIST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .batt_vld    (batt_vld),
      .batt        (batt),
      .spd_vld     (spd_vld),
      .spd         (spd),
      .en_steer_in (en_steer_in),
      .batt_low    (batt_low),
      .too_fast    (too_fast),
      .en_steer    (en_steer)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [2:0] exp;   // {batt_low, too_fast, en_steer}
      int         due;   // cycle count at which the outputs must show exp
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: plain running sums and run-length counts per channel.
   int b_idx, b_sum, b_pc;
   int s_idx, s_sum, s_pc;
   bit b_flag, s_flag;
   bit pb, ps;           // flags as visible one edge after the model decides

   function automatic void model_clear();
      b_idx = 0; b_sum = 0; b_pc = 0; b_flag = 0;
      s_idx = 0; s_sum = 0; s_pc = 0; s_flag = 0;
      pb = 0; ps = 0;
   endfunction

   function automatic void chan_update(input bit is_batt, input int x,
                                       inout int idx, inout int sum,
                                       inout int pc, inout bit flag);
      int avg;
      bit q;
      sum += x;
      idx++;
      if (idx == N) begin
         avg = sum / N;
         if (!flag) begin
            q = is_batt ? (avg < BATT_LO_TH) : (avg > SPD_HI_TH);
         end else if (is_batt) begin
`ifdef STICKY_BATT_LOW_EN
            q = 1'b0;
`else
            q = (avg >= BATT_CLR);
`endif
         end else begin
            q = (avg <= SPD_CLR);
         end
         if (q) begin
            pc++;
            if (pc == PERSIST) begin
               flag = !flag;
               pc   = 0;
            end
         end else begin
            pc = 0;
         end
         sum = 0;
         idx = 0;
      end
   endfunction

   // Drive one cycle of stimulus and push the outputs expected after the next edge.
   task automatic step(input bit r, input bit bv, input int b,
                       input bit sv, input int s, input bit en);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = r;
      batt_vld    = bv;
      batt        = 12'(b);
      spd_vld     = sv;
      spd         = 12'(s);
      en_steer_in = en;
      if (r) begin
         model_clear();
         e.exp = 3'b000;
      end else begin
         e.exp = {pb, ps, en};
         if (bv) chan_update(1'b1, b, b_idx, b_sum, b_pc, b_flag);
         if (sv) chan_update(1'b0, s, s_idx, s_sum, s_pc, s_flag);
         pb = b_flag;
         ps = s_flag;
      end
      e.due = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic batt_win(input int v);
      for (int i = 0; i < N; i++) step(1'b0, 1'b1, v, 1'b0, 0, 1'b0);
   endtask

   task automatic spd_win(input int v);
      for (int i = 0; i < N; i++) step(1'b0, 1'b0, 0, 1'b1, v, 1'b0);
   endtask

   function automatic int clamp12(input int v);
      return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
   endfunction

   // Monitor: compares outputs against the scoreboard, away from the clock edge.
   initial begin
      exp_t       m;
      logic [2:0] got;
      forever begin
         @(posedge clk);
         #3;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            m   = sb.pop_front();
            got = {batt_low, too_fast, en_steer};
            vectors++;
            if (m.due != cyc) begin
               miscompares++;
               $display("FAIL stale_entry cyc=%0d due=%0d", cyc, m.due);
            end else if (got !== m.exp) begin
               miscompares++;
               $display("FAIL outputs cyc=%0d {batt_low,too_fast,en_steer} got=%b exp=%b",
                        cyc, got, m.exp);
            end
         end
      end
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   int batt_lvls[8] = '{'h900, 'hAA0, 'hAE0, 'hA98, 'hA97, 'hAD8, 'hAD7, 'hFFF};
   int spd_lvls[8]  = '{'h700, 'h500, 'h600, 'h601, 'h580, 'h581, 'h000, 'hFFF};

   initial begin
      model_clear();

      // Reset held two cycles with strobes and enable active.
      step(1'b1, 1'b1, 'h100, 1'b1, 'h700, 1'b1);
      step(1'b1, 1'b1, 'h100, 1'b1, 'h700, 1'b1);

      // Three low-battery windows: batt_low rises two cycles after the 12th strobe.
      batt_win('h900); batt_win('h900); batt_win('h900);
      idle(3);

      // In-band averages hold the flag; above-band averages release it.
      batt_win('hAA0); batt_win('hAA0); batt_win('hAA0);
      idle(3);
      batt_win('hAE0); batt_win('hAE0); batt_win('hAE0);
      idle(3);

      // Exact boundaries: A98 does not qualify for set, A97 does.
      if (!b_flag) begin
         batt_win('hA98); batt_win('hA98); batt_win('hA98);
         idle(2);
      end

      // Persistence break on the speed channel.
      spd_win('h700); spd_win('h700); spd_win('h500);
      spd_win('h700); spd_win('h700);
      idle(2);
      spd_win('h700);
      idle(3);

      // Simultaneous strobes every cycle, enable toggling.
      step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 'h800, 1'b1, 'h7FF, i[0]);
      idle(3);

      // Set batt_low, then full-scale windows: release only when not sticky.
      step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      batt_win('hA97); batt_win('hA97); batt_win('hA97);
      idle(2);
      batt_win('hFFF); batt_win('hFFF); batt_win('hFFF);
      idle(3);
      step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      idle(2);

      // Reset mid-window discards the partial sum.
      step(1'b0, 1'b1, 'h100, 1'b1, 'hF00, 1'b1);
      step(1'b0, 1'b1, 'h100, 1'b1, 'hF00, 1'b1);
      step(1'b1, 1'b1, 'h100, 1'b1, 'hF00, 1'b1);
      batt_win('hFFF);
      idle(2);

      // Randomized regimes near the thresholds.
      for (int blk = 0; blk < 60; blk++) begin
         int bb, ss;
         bb = batt_lvls[$urandom_range(0, 7)];
         ss = spd_lvls[$urandom_range(0, 7)];
         if ($urandom_range(0, 5) == 0) bb = $urandom_range(0, 4095);
         if ($urandom_range(0, 5) == 0) ss = $urandom_range(0, 4095);
         for (int k = 0; k < 40; k++) begin
            int  bj, sj;
            bit  r, bv, sv, en;
            bj = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 64)) - 32;
            sj = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 64)) - 32;
            r  = ($urandom_range(0, 299) == 0);
            bv = ($urandom_range(0, 2) != 0);
            sv = ($urandom_range(0, 2) != 0);
            en = $urandom_range(0, 1) != 0;
            step(r, bv, clamp12(bb + bj), sv, clamp12(ss + sj), en);
         end
      end

      idle(4);
      repeat (3) @(posedge clk);
      #5;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
